// File: rtl/adc_spi_rx.sv
// adc_spi_rx: serial front end for a 12-bit ADC7476-class converter.
// Generates cs_n/sclk, shifts in 16-bit frames, strobes each sample out.
module adc_spi_rx #(
  parameter int CLK_DIV = 4,
  parameter int CSU     = 2,
  parameter int QUIET   = 4
) (
  input  logic        ck,
  input  logic        rst,
  input  logic        start,
  input  logic        cont,
  input  logic        miso,
  output logic        cs_n,
  output logic        sclk,
  output logic        busy,
  output logic [11:0] data,
  output logic        ld,
  output logic        err
);

  localparam int M1 = (CLK_DIV > CSU) ? CLK_DIV : CSU;
  localparam int MX = (M1 > QUIET) ? M1 : QUIET;
  localparam int CW = $clog2(MX + 1);

  localparam logic [CW-1:0] DIV_L = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CSU_L = CW'(CSU - 1);
  localparam logic [CW-1:0] QT_L  = CW'(QUIET - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_DONE,
    S_QUIET
  } state_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    bcnt, bcnt_n;
  logic          hi, hi_n;
  logic          smp;
  logic [15:0]   shift;

  // Next state plus next counter/phase values; counters restart on
  // every state change, so SHIFT always begins with bit 0, low half.
  always_comb begin
    nxt    = state;
    cnt_n  = '0;
    bcnt_n = '0;
    hi_n   = 1'b0;
    smp    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start || cont) nxt = S_LEAD;
      end
      S_LEAD: begin
        if (cnt == CSU_L) nxt = S_SHIFT;
        else cnt_n = cnt + 1'b1;
      end
      S_SHIFT: begin
        if (cnt != DIV_L) begin
          cnt_n  = cnt + 1'b1;
          hi_n   = hi;
          bcnt_n = bcnt;
        end else if (!hi) begin
          smp    = 1'b1;
          hi_n   = 1'b1;
          bcnt_n = bcnt;
        end else if (bcnt == 4'd15) begin
          nxt = S_DONE;
        end else begin
          bcnt_n = bcnt + 4'd1;
        end
      end
      S_DONE: begin
        nxt = S_QUIET;
      end
      S_QUIET: begin
        if (cnt == QT_L) nxt = S_IDLE;
        else cnt_n = cnt + 1'b1;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // State, counters and the frame shift register.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      bcnt  <= '0;
      hi    <= 1'b0;
      shift <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_n;
      bcnt  <= bcnt_n;
      hi    <= hi_n;
      if (smp) shift <= {shift[14:0], miso};
    end
  end

  // Registered outputs decoded from the next state so pins are glitch-free.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      cs_n <= 1'b1;
      sclk <= 1'b1;
      busy <= 1'b0;
      ld   <= 1'b0;
      err  <= 1'b0;
      data <= '0;
    end else begin
      cs_n <= !(nxt == S_LEAD || nxt == S_SHIFT);
      sclk <= !(nxt == S_SHIFT && !hi_n);
      busy <= (nxt != S_IDLE);
      ld   <= (nxt == S_DONE);
      err  <= (nxt == S_DONE) && (|shift[15:12]);
      if (nxt == S_DONE) data <= shift[11:0];
    end
  end

endmodule
